// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// Holds the FSM state enum, ALU control codes, data-processing cmd codes
// and flag bit positions used by the controller and condition checker.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  typedef logic [1:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 2'b00;
  localparam alu_ctrl_t ALU_SUB = 2'b01;
  localparam alu_ctrl_t ALU_AND = 2'b10;
  localparam alu_ctrl_t ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Map a data-processing cmd onto the ALU; unknown cmds fall back to ADD.
  function automatic alu_ctrl_t dp_alu_ctrl(input logic [3:0] cmd);
    alu_ctrl_t res;
    case (cmd)
      CMD_SUB, CMD_CMP: res = ALU_SUB;
      CMD_AND:          res = ALU_AND;
      CMD_ORR:          res = ALU_ORR;
      default:          res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/Condcheck.sv
// ARM condition-code evaluator: decides whether the current instruction executes.
// Purely combinational, evaluated against the architectural (registered) flags.
// AL and the unconditional 1111 space both execute.
module Condcheck
  import ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  // Standard ARM condition table.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = ge;
      4'b1011: CondEx = ~ge;
      4'b1100: CondEx = ~z & ge;
      4'b1101: CondEx = z | ~ge;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle ARM-subset CPU: fetch/decode/execute/memory/writeback.
// Owns the NZCV flags; predicated-off instructions return to FETCH from DECODE.
// Memory states hold until mem_ready; datapath controls are Moore on state, gated by mem_ready/CondEx.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic       illegal
);

  state_t     state;
  logic       cond_ex;
  logic [3:0] cmd;
  logic       s_bit;
  logic       cmd_known;
  logic       cmd_arith;
  logic       flag_we;
  logic       pc_dest;

  Condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  assign cmd     = Funct[4:1];
  assign s_bit   = Funct[0];
  assign pc_dest = (Rd == PC_REG);

  // Classify the data-processing cmd: which flags it may write and whether at all.
  always_comb begin
    cmd_known = 1'b0;
    cmd_arith = 1'b0;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_CMP: begin
        cmd_known = 1'b1;
        cmd_arith = 1'b1;
      end
      CMD_AND, CMD_ORR: cmd_known = 1'b1;
      default: ;
    endcase
    flag_we = cmd_known && (s_bit || (cmd == CMD_CMP));
  end

  // State sequencing and the architectural flags register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      Flags <= 4'b0000;
    end else begin
      case (state)
        FETCH: if (mem_ready) state <= DECODE;
        DECODE: begin
          if (!cond_ex) begin
            state <= FETCH;
          end else begin
            case (Op)
              OP_DP:   state <= Funct[5] ? EXECI : EXECR;
              OP_MEM:  state <= MEMADR;
              OP_BR:   state <= BRANCH;
              default: state <= FETCH;
            endcase
          end
        end
        EXECR, EXECI: begin
          if (flag_we) begin
            Flags[FLAG_N] <= ALUFlags[FLAG_N];
            Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            if (cmd_arith) begin
              Flags[FLAG_C] <= ALUFlags[FLAG_C];
              Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
          end
          state <= (cmd == CMD_CMP) ? FETCH : ALUWB;
        end
        MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) state <= MEMWB;
        MEMWR:  if (mem_ready) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Datapath controls decoded from state; everything is forced low while reset is held.
  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    if (reset_n) begin
      // Once the instruction is latched, keep the extender and register-read
      // selects tracking it so EXECI/MEMADR/BRANCH see a valid immediate.
      if (state != FETCH) begin
        ImmSrc = Op;
        RegSrc = {(Op == OP_MEM), (Op == OP_BR)};
      end
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        DECODE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          illegal = cond_ex && (Op == 2'b11);
        end
        EXECR: ALUControl = dp_alu_ctrl(cmd);
        EXECI: begin
          ALUSrcB    = 2'b01;
          ALUControl = dp_alu_ctrl(cmd);
        end
        ALUWB, MEMWB: begin
          ResultSrc = (state == MEMWB) ? 2'b01 : 2'b00;
          if (pc_dest) PCWrite = 1'b1;
          else         RegWrite = 1'b1;
        end
        MEMADR: begin
          ALUSrcB    = 2'b01;
          ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
        end
        MEMRD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = mem_ready;
        end
        BRANCH: begin
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction sequences cycle by cycle
// and compares the full control word and Flags against hand-computed values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       mem_ready;
  logic       mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.PC_REG(4'd15)) dut (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags), .illegal(illegal)
  );

  // {mem_req,PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,RegSrc,ALUControl,illegal}
  logic [17:0] ctl;
  assign ctl = {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, illegal};

  function automatic logic [17:0] w(input logic mr, pcw, irw, rw, mw, adr, sa,
                                    input logic [1:0] sb, rs, im, rg, al,
                                    input logic il);
    return {mr, pcw, irw, rw, mw, adr, sa, sb, rs, im, rg, al, il};
  endfunction

  function automatic logic [17:0] exp_fetch(input logic r);
    return w(1'b1, r, r, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
  endfunction

  function automatic logic [17:0] exp_decode(input logic [1:0] im, rg, input logic il);
    return w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, im, rg, 2'b00, il);
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
    checks++;
    assert (Flags === exp) else begin
      errors++;
      $error("FAIL %s: observed Flags=%b expected %b", tag, Flags, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r);
    Cond = c; Op = o; Funct = f; Rd = r;
  endtask

  initial begin
    reset_n = 1'b1; mem_ready = 1'b1; ALUFlags = 4'b0000;
    set_instr(4'b1110, 2'b00, 6'b000000, 4'd0);
    #1 reset_n = 1'b0;
    #2;
    chk("reset_ctl", ctl, 18'd0);
    chk_flags("reset_flags", 4'b0000);
    tick();
    chk("reset_ctl_after_edge", ctl, 18'd0);

    // Release reset into FETCH with memory not ready: hold.
    reset_n = 1'b1; mem_ready = 1'b0;
    #1 chk("fetch_wait", ctl, exp_fetch(1'b0));
    tick();
    chk("fetch_hold", ctl, exp_fetch(1'b0));

    // ADDS R1 (register form -> EXECR), ALUFlags 0110.
    set_instr(4'b1110, 2'b00, 6'b001001, 4'd1); ALUFlags = 4'b0110; mem_ready = 1'b1;
    #1 chk("adds_fetch", ctl, exp_fetch(1'b1));
    tick(); chk("adds_decode", ctl, exp_decode(2'b00, 2'b00, 1'b0));
    tick(); chk("adds_execr", ctl, w(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tick(); chk("adds_aluwb", ctl, w(0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    chk_flags("adds_flags", 4'b0110);
    tick();

    // Reset asserted in EXECR of another ADDS: flags cleared, no later update.
    set_instr(4'b1110, 2'b00, 6'b001001, 4'd2); ALUFlags = 4'b1001;
    #1 chk("rst_fetch", ctl, exp_fetch(1'b1));
    tick(); tick();
    reset_n = 1'b0;
    #1 chk("rst_mid_ctl", ctl, 18'd0);
    chk_flags("rst_mid_flags", 4'b0000);
    tick();
    chk_flags("rst_edge_flags", 4'b0000);

    // Resume: fresh fetch of ADDS R1 with ALUFlags 0100.
    reset_n = 1'b1;
    set_instr(4'b1110, 2'b00, 6'b001001, 4'd1); ALUFlags = 4'b0100;
    #1 chk("rst_resume_fetch", ctl, exp_fetch(1'b1));
    chk_flags("rst_resume_flags", 4'b0000);
    tick(); tick(); tick();
    chk_flags("adds2_flags", 4'b0100);
    tick();

    // SUBSNE with Z=1: skipped from DECODE, no side effects.
    set_instr(4'b0001, 2'b00, 6'b000101, 4'd4); ALUFlags = 4'b1111;
    #1 chk("subne_fetch", ctl, exp_fetch(1'b1));
    tick(); chk("subne_decode", ctl, exp_decode(2'b00, 2'b00, 1'b0));
    tick(); mem_ready = 1'b0;
    #1 chk("subne_back_fetch", ctl, exp_fetch(1'b0));
    chk_flags("subne_flags", 4'b0100);

    // LDR R3 with mem_ready low for 3 cycles in MEMRD.
    mem_ready = 1'b1;
    set_instr(4'b1110, 2'b01, 6'b011001, 4'd3);
    #1 chk("ldr_fetch", ctl, exp_fetch(1'b1));
    tick(); chk("ldr_decode", ctl, exp_decode(2'b01, 2'b10, 1'b0));
    mem_ready = 1'b0;
    tick(); chk("ldr_memadr", ctl, w(0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 0));
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ldr_memrd_wait", ctl, w(1,0,0,0,0,1,0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0));
    end
    mem_ready = 1'b1;
    #1 chk("ldr_memrd_done", ctl, w(1,0,0,0,0,1,0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0));
    tick(); chk("ldr_memwb", ctl, w(0,0,0,1,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 0));
    tick();

    // STR (U=0 -> SUB address) with one wait cycle.
    set_instr(4'b1110, 2'b01, 6'b010000, 4'd5);
    #1 chk("str_fetch", ctl, exp_fetch(1'b1));
    tick(); chk("str_decode", ctl, exp_decode(2'b01, 2'b10, 1'b0));
    tick(); chk("str_memadr", ctl, w(0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01, 0));
    mem_ready = 1'b0;
    tick(); chk("str_memwr_wait", ctl, w(1,0,0,0,0,1,0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0));
    mem_ready = 1'b1;
    #1 chk("str_memwr_go", ctl, w(1,0,0,0,1,1,0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0));
    tick(); mem_ready = 1'b0;
    #1 chk("str_back_fetch", ctl, exp_fetch(1'b0));

    // ADDS to load Flags=0011, then ORRS with ALUFlags 1000 -> 1011.
    mem_ready = 1'b1;
    set_instr(4'b1110, 2'b00, 6'b001001, 4'd1); ALUFlags = 4'b0011;
    tick(); tick(); tick();
    chk_flags("adds3_flags", 4'b0011);
    tick();
    set_instr(4'b1110, 2'b00, 6'b011001, 4'd6); ALUFlags = 4'b1000;
    tick(); tick();
    chk("orrs_execr", ctl, w(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0));
    tick(); chk_flags("orrs_flags", 4'b1011);
    tick();

    // CMP (S=0, flags forced): 3 cycles, no RegWrite.
    set_instr(4'b1110, 2'b00, 6'b010100, 4'd0); ALUFlags = 4'b0101;
    #1 chk("cmp_fetch", ctl, exp_fetch(1'b1));
    tick(); chk("cmp_decode", ctl, exp_decode(2'b00, 2'b00, 1'b0));
    tick(); chk("cmp_execr", ctl, w(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0));
    tick();
    set_instr(4'b1110, 2'b11, 6'b000000, 4'd0);
    #1 chk("cmp_back_fetch", ctl, exp_fetch(1'b1));
    chk_flags("cmp_flags", 4'b0101);

    // Op=11: illegal pulses in DECODE only.
    tick(); chk("illegal_decode", ctl, exp_decode(2'b11, 2'b00, 1'b1));
    tick();
    set_instr(4'b1110, 2'b00, 6'b001000, 4'd15); ALUFlags = 4'b1111;
    #1 chk("illegal_back_fetch", ctl, exp_fetch(1'b1));

    // ADD R15 (no S): ALUWB redirects PC, no RegWrite, flags hold.
    tick(); tick(); tick();
    chk("pc_aluwb", ctl, w(0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    chk_flags("pc_flags", 4'b0101);
    tick();

    // Branch: 3 cycles.
    set_instr(4'b1110, 2'b10, 6'b100000, 4'd0);
    #1 chk("b_fetch", ctl, exp_fetch(1'b1));
    tick(); chk("b_decode", ctl, exp_decode(2'b10, 2'b01, 1'b0));
    tick(); chk("b_branch", ctl, w(0,1,0,0,0,0,0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 0));
    tick(); mem_ready = 1'b0;
    #1 chk("b_back_fetch", ctl, exp_fetch(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
